// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave cook controller: state encoding, BCD limits, add-30 step.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package microwave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] BCD_ZERO     = 4'd0;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] BCD_MAX      = 4'd9;
    // Add-30 is applied as +3 on the tens-of-seconds digit.
    localparam logic [3:0] ADD30        = 4'd3;

    localparam int DEF_TICKS_PER_SEC = 100;

    // Keypad codes above 9 are not digits and must not be entered.
    function automatic logic is_bcd_digit(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// BCD MM:SS time register: clear, key shift-in, 1 s decrement, optional +30 s / load 00:30.
// Latency: one clock from any control strobe to the updated digits.
// Backpressure: none; strobes are mutually prioritised clear > load30 > add30 > dec > shift.
module bcd_mmss_counter
    import microwave_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       shift_i,
    input  logic [3:0] digit_i,
    input  logic       dec_i,
`ifdef MICROWAVE_ADD30_EN
    input  logic       add30_i,
    input  logic       load30_i,
`endif
    output logic [3:0] min_tens_o,
    output logic [3:0] min_ones_o,
    output logic [3:0] sec_tens_o,
    output logic [3:0] sec_ones_o,
    output logic       zero_o,
    output logic       last_sec_o
);

    logic [3:0] mt_q, mo_q, st_q, so_q;
    logic [3:0] mt_d, mo_d, st_d, so_d;

    // Next-time selection; the decrement borrows digit by digit and never runs below 00:00.
    always_comb begin
        mt_d = mt_q;
        mo_d = mo_q;
        st_d = st_q;
        so_d = so_q;
        if (clear_i) begin
            mt_d = BCD_ZERO;
            mo_d = BCD_ZERO;
            st_d = BCD_ZERO;
            so_d = BCD_ZERO;
`ifdef MICROWAVE_ADD30_EN
        end else if (load30_i) begin
            mt_d = BCD_ZERO;
            mo_d = BCD_ZERO;
            st_d = ADD30;
            so_d = BCD_ZERO;
        end else if (add30_i) begin
            if (st_q >= (SEC_TENS_MAX + 4'd1 - ADD30)) begin
                st_d = st_q + ADD30 - (SEC_TENS_MAX + 4'd1);
                if (mo_q == BCD_MAX) begin
                    if (mt_q == BCD_MAX) begin
                        // Already at the top minute: pin to 99:59.
                        st_d = SEC_TENS_MAX;
                        so_d = BCD_MAX;
                    end else begin
                        mo_d = BCD_ZERO;
                        mt_d = mt_q + 4'd1;
                    end
                end else begin
                    mo_d = mo_q + 4'd1;
                end
            end else begin
                st_d = st_q + ADD30;
            end
`endif
        end else if (dec_i && !zero_o) begin
            if (so_q != BCD_ZERO) begin
                so_d = so_q - 4'd1;
            end else begin
                so_d = BCD_MAX;
                if (st_q != BCD_ZERO) begin
                    st_d = st_q - 4'd1;
                end else begin
                    st_d = SEC_TENS_MAX;
                    if (mo_q != BCD_ZERO) begin
                        mo_d = mo_q - 4'd1;
                    end else begin
                        mo_d = BCD_MAX;
                        mt_d = mt_q - 4'd1;
                    end
                end
            end
        end else if (shift_i && is_bcd_digit(digit_i)) begin
            mt_d = mo_q;
            mo_d = st_q;
            st_d = so_q;
            so_d = digit_i;
        end
    end

    // Digit registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mt_q <= BCD_ZERO;
            mo_q <= BCD_ZERO;
            st_q <= BCD_ZERO;
            so_q <= BCD_ZERO;
        end else begin
            mt_q <= mt_d;
            mo_q <= mo_d;
            st_q <= st_d;
            so_q <= so_d;
        end
    end

    assign min_tens_o = mt_q;
    assign min_ones_o = mo_q;
    assign sec_tens_o = st_q;
    assign sec_ones_o = so_q;
    assign zero_o     = (mt_q == BCD_ZERO) && (mo_q == BCD_ZERO) &&
                        (st_q == BCD_ZERO) && (so_q == BCD_ZERO);
    // 00:01 means the next decrement lands on 00:00.
    assign last_sec_o = (mt_q == BCD_ZERO) && (mo_q == BCD_ZERO) &&
                        (st_q == BCD_ZERO) && (so_q == 4'd1);

endmodule

// File: rtl/microwave_cook_controller.sv
// Cook-cycle sequencer: keypad entry, 1 s BCD countdown from tick prescaler, door interlock, beeper.
// Latency: registered state/digits update one clock after the strobe; mag_on drops combinationally on door open.
// Backpressure: none; same-cycle priority reset > door open > stop_clear > start > tick > key. Option macro: MICROWAVE_ADD30_EN.
module microwave_cook_controller
    import microwave_pkg::*;
#(
    parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
    parameter int BEEP_SECS     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    output logic       mag_on,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       done_beep,
    output logic [1:0] state_o
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int BW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_SECS - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] beep_q, beep_d;

    logic cnt_clear, cnt_shift, cnt_dec;
    logic cnt_zero, cnt_last_sec;
`ifdef MICROWAVE_ADD30_EN
    logic cnt_add30, cnt_load30;
`endif

    // Next-state, prescaler/beep timer and counter strobes.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        beep_d    = beep_q;
        cnt_clear = 1'b0;
        cnt_shift = 1'b0;
        cnt_dec   = 1'b0;
`ifdef MICROWAVE_ADD30_EN
        cnt_add30  = 1'b0;
        cnt_load30 = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && door_closed && !cnt_zero) begin
                    state_d = ST_COOK;
                    presc_d = '0;
`ifdef MICROWAVE_ADD30_EN
                end else if (start && door_closed && cnt_zero) begin
                    cnt_load30 = 1'b1;
                    state_d    = ST_COOK;
                    presc_d    = '0;
`endif
                end else if (key_valid) begin
                    cnt_shift = 1'b1;
                end
            end
            ST_COOK: begin
                // Door open and stop both pause with the prescaler frozen.
                if (!door_closed || stop_clear) begin
                    state_d = ST_PAUSE;
`ifdef MICROWAVE_ADD30_EN
                end else if (start) begin
                    cnt_add30 = 1'b1;
`endif
                end else if (tick) begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        cnt_dec = 1'b1;
                        if (cnt_last_sec) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop_clear) begin
                    state_d   = ST_IDLE;
                    cnt_clear = 1'b1;
                    presc_d   = '0;
                end else if (start && door_closed) begin
                    state_d = ST_COOK;
                end
            end
            ST_DONE: begin
                if (stop_clear || key_valid) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                    beep_d  = '0;
                end else if (tick) begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (beep_q == BEEP_LAST) begin
                            state_d = ST_IDLE;
                            beep_d  = '0;
                        end else begin
                            beep_d = beep_q + 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, prescaler and beep-second registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            beep_q  <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            beep_q  <= beep_d;
        end
    end

    bcd_mmss_counter u_time (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (cnt_clear),
        .shift_i    (cnt_shift),
        .digit_i    (key_digit),
        .dec_i      (cnt_dec),
`ifdef MICROWAVE_ADD30_EN
        .add30_i    (cnt_add30),
        .load30_i   (cnt_load30),
`endif
        .min_tens_o (min_tens),
        .min_ones_o (min_ones),
        .sec_tens_o (sec_tens),
        .sec_ones_o (sec_ones),
        .zero_o     (cnt_zero),
        .last_sec_o (cnt_last_sec)
    );

    // Door input gates power directly so opening cuts the magnetron in the same cycle.
    assign mag_on    = (state_q == ST_COOK) && door_closed;
    assign done_beep = (state_q == ST_DONE);
    assign state_o   = state_q;

endmodule

// File: tb/tb_microwave_cook_controller.sv
// Directed bench for microwave_cook_controller with a queue-based scoreboard.
// Stimulus pushes expected state/outputs and raises a check request; a monitor compares on the falling edge.
// TICKS_PER_SEC=4, BEEP_SECS=3 so one second is four ticks.
module tb_microwave_cook_controller;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COOK  = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic       clk = 1'b0;
    logic       reset, tick, key_valid, start, stop_clear, door_closed;
    logic [3:0] key_digit;
    logic       mag_on, done_beep;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [1:0] state_o;

    int checks   = 0;
    int failures = 0;

    string       name_q[$];
    logic [19:0] exp_q[$];
    logic        chk_req = 1'b0;

    microwave_cook_controller #(
        .TICKS_PER_SEC (4),
        .BEEP_SECS     (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .start       (start),
        .stop_clear  (stop_clear),
        .door_closed (door_closed),
        .mag_on      (mag_on),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .done_beep   (done_beep),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    // Monitor: compares the presented outputs against the oldest queued expectation.
    always @(negedge clk) begin
        logic [19:0] act, e;
        string       nm;
        if (chk_req) begin
            act = {state_o, mag_on, done_beep, min_tens, min_ones, sec_tens, sec_ones};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow: check requested with no expected entry");
            end else begin
                nm = name_q.pop_front();
                e  = exp_q.pop_front();
                if (act !== e) begin
                    failures++;
                    $display("FAIL %s: got st=%0d mag=%0b beep=%0b time=%h:%h, expected st=%0d mag=%0b beep=%0b time=%h:%h",
                             nm, act[19:18], act[17], act[16], act[15:8], act[7:0],
                             e[19:18], e[17], e[16], e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [1:0] st, input logic mag,
                              input logic beep, input logic [15:0] t);
        name_q.push_back(nm);
        exp_q.push_back({st, mag, beep, t});
        chk_req = 1'b1;
        @(negedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        cycle();
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop_clear = 1'b1;
        cycle();
        stop_clear = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cycle();
        end
        tick = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; tick = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
        start = 1'b0; stop_clear = 1'b0; door_closed = 1'b1;
        repeat (2) cycle();
        expect_out("reset", S_IDLE, 1'b0, 1'b0, 16'h0000);
        reset = 1'b0;
        cycle();

        // Shift-in entry and countdown.
        key(4'd1); key(4'd3); key(4'd0);
        expect_out("entry_0130", S_IDLE, 1'b0, 1'b0, 16'h0130);
        do_start();
        expect_out("start_cook", S_COOK, 1'b1, 1'b0, 16'h0130);
        ticks(3);
        expect_out("presc_no_dec", S_COOK, 1'b1, 1'b0, 16'h0130);
        ticks(1);
        expect_out("first_dec", S_COOK, 1'b1, 1'b0, 16'h0129);
        ticks(120);
        expect_out("after_31s", S_COOK, 1'b1, 1'b0, 16'h0059);
        do_stop();
        expect_out("stop_pause", S_PAUSE, 1'b0, 1'b0, 16'h0059);
        do_stop();
        expect_out("clear_idle", S_IDLE, 1'b0, 1'b0, 16'h0000);

        // Rejections.
        do_start();
`ifdef MICROWAVE_ADD30_EN
        expect_out("start_zero_load30", S_COOK, 1'b1, 1'b0, 16'h0030);
        do_stop();
        do_stop();
        expect_out("back_idle", S_IDLE, 1'b0, 1'b0, 16'h0000);
`else
        expect_out("start_zero_ignored", S_IDLE, 1'b0, 1'b0, 16'h0000);
`endif
        key(4'd2);
        key(4'd12);
        expect_out("key_12_ignored", S_IDLE, 1'b0, 1'b0, 16'h0002);
        door_closed = 1'b0;
        do_start();
        expect_out("start_door_open", S_IDLE, 1'b0, 1'b0, 16'h0002);
        door_closed = 1'b1;

        // Countdown to DONE, beep timing.
        do_start();
        ticks(8);
        expect_out("reach_done", S_DONE, 1'b0, 1'b1, 16'h0000);
        ticks(11);
        expect_out("beep_held", S_DONE, 1'b0, 1'b1, 16'h0000);
        ticks(1);
        expect_out("beep_end", S_IDLE, 1'b0, 1'b0, 16'h0000);

        // Door interlock with prescaler held.
        key(4'd5);
        do_start();
        ticks(2);
        door_closed = 1'b0;
        expect_out("door_cut_same_cycle", S_COOK, 1'b0, 1'b0, 16'h0005);
        cycle();
        expect_out("door_pause", S_PAUSE, 1'b0, 1'b0, 16'h0005);
        ticks(3);
        expect_out("pause_ignores_tick", S_PAUSE, 1'b0, 1'b0, 16'h0005);
        key(4'd7);
        expect_out("pause_ignores_key", S_PAUSE, 1'b0, 1'b0, 16'h0005);
        door_closed = 1'b1;
        do_start();
        ticks(1);
        expect_out("resume_held_presc", S_COOK, 1'b1, 1'b0, 16'h0005);
        ticks(1);
        expect_out("resume_dec", S_COOK, 1'b1, 1'b0, 16'h0004);

        // Tick at terminal count together with stop_clear.
        ticks(3);
        tick = 1'b1;
        stop_clear = 1'b1;
        cycle();
        tick = 1'b0;
        stop_clear = 1'b0;
        expect_out("tick_stop_same", S_PAUSE, 1'b0, 1'b0, 16'h0004);
        do_stop();
        expect_out("second_stop", S_IDLE, 1'b0, 1'b0, 16'h0000);

        // Minute borrow, then reset mid-cook.
        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        do_start();
        ticks(4);
        expect_out("borrow_1000", S_COOK, 1'b1, 1'b0, 16'h0959);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        expect_out("reset_mid_cook", S_IDLE, 1'b0, 1'b0, 16'h0000);

        // Unnormalised seconds count digit-wise.
        key(4'd9); key(4'd9);
        do_start();
        ticks(4);
        expect_out("sec99_digitwise", S_COOK, 1'b1, 1'b0, 16'h0098);
        do_stop();
        do_stop();

        // Early exit from DONE on a key; digit not captured.
        key(4'd1);
        do_start();
        ticks(4);
        expect_out("done_from_0001", S_DONE, 1'b0, 1'b1, 16'h0000);
        key(4'd7);
        expect_out("done_key_exit", S_IDLE, 1'b0, 1'b0, 16'h0000);

`ifdef MICROWAVE_ADD30_EN
        key(4'd9); key(4'd9); key(4'd4); key(4'd5);
        do_start();
        expect_out("cook_9945", S_COOK, 1'b1, 1'b0, 16'h9945);
        do_start();
        expect_out("add30_saturate", S_COOK, 1'b1, 1'b0, 16'h9959);
        do_stop();
        do_stop();
`endif

        cycle();
        if (exp_q.size() != 0) begin
            failures += exp_q.size();
            $display("FAIL scoreboard_leftover: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
